// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer: start bit, LSB-first payload, optional even parity, stop bits
//
// Purpose: serialises one DATA_BITS-wide payload per frame onto tx. Bit timing comes
// from an external baud pulse generator: baud_en starts it, and baud_pulse marks each
// bit-period boundary.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit after the payload.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   tx_data    in   payload, captured on acceptance (tx_valid && tx_ready)
//   tx_valid   in   upstream offers tx_data
//   tx_ready   out  high only while idle; a byte may be accepted
//   baud_en    out  enable for the baud pulse generator, high while a frame is in progress
//   baud_pulse in   one-cycle bit-period tick
//   tx         out  serial line, idle high
//   busy       out  a frame is in progress
module uart_tx_framer #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 baud_en,
    input  logic                 baud_pulse,
    output logic                 tx,
    output logic                 busy
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 baud_en_q, baud_en_d;
    logic                 busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                // baud_pulse is deliberately ignored here; only the handshake matters.
                if (tx_valid && tx_ready_q) begin
                    shreg_d    = tx_data;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d   = ^tx_data;
`endif
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (baud_pulse) state_d = S_DATA;
            end
            S_DATA: begin
                if (baud_pulse) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = S_PARITY;
`else
                        state_d   = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_pulse) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (baud_pulse) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        stop_cnt_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so the registered line changes on the
        // same edge as the state: one cycle from acceptance to the start-bit edge.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        tx_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
        // Leaving STOP always passes through one IDLE cycle with baud_en low, which
        // restarts the generator's phase for the next frame.
        baud_en_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b0;
            baud_en_q  <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
            baud_en_q  <= baud_en_d;
            busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign tx_ready = tx_ready_q;
    assign baud_en  = baud_en_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - testbench for uart_tx_framer (1 and 2 stop-bit lanes)
`timescale 1ns/1ps
module tb_uart_tx_framer;

`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    int         period = 6;
    int         checks = 0;
    int         errors = 0;

    logic       tx_w[2];
    logic       busy_w[2];
    logic       ready_w[2];
    logic       baud_en_w[2];
    logic       baud_pulse_w[2];
    logic       tx_valid_r[2];
    logic [7:0] tx_data_r[2];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole frame as the line must show it, bit 0 first; unused upper bits stay high.
    function automatic logic [15:0] make_frame(input logic [7:0] d);
        logic [15:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int SB    = g + 1;
        localparam int NBITS = 1 + 8 + PB + SB;

        int          bcnt;
        logic        m_act;
        logic        m_ready;
        logic [15:0] m_frame;
        int          m_pos;
        int          m_tick;

        uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(SB)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .tx_data    (tx_data_r[g]),
            .tx_valid   (tx_valid_r[g]),
            .tx_ready   (ready_w[g]),
            .baud_en    (baud_en_w[g]),
            .baud_pulse (baud_pulse_w[g]),
            .tx         (tx_w[g]),
            .busy       (busy_w[g])
        );

        // Baud pulse generator: one pulse every `period` cycles while enabled.
        always @(posedge clk) begin
            if (!baud_en_w[g] || bcnt == period - 1) bcnt <= 0;
            else bcnt <= bcnt + 1;
        end
        assign baud_pulse_w[g] = baud_en_w[g] && (bcnt == period - 1);

        // Model: each frame bit occupies exactly `period` cycles; ready returns on the
        // edge the last stop bit ends and a new byte is taken on a later edge.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                m_act   <= 1'b0;
                m_ready <= 1'b0;
                m_frame <= '1;
                m_pos   <= 0;
                m_tick  <= 0;
            end else if (m_act) begin
                if (m_tick == period - 1) begin
                    m_tick <= 0;
                    m_pos  <= m_pos + 1;
                    if (m_pos == NBITS - 1) begin
                        m_act   <= 1'b0;
                        m_ready <= 1'b1;
                    end
                end else begin
                    m_tick <= m_tick + 1;
                end
            end else if (m_ready && tx_valid_r[g]) begin
                m_act   <= 1'b1;
                m_ready <= 1'b0;
                m_pos   <= 0;
                m_tick  <= 0;
                m_frame <= make_frame(tx_data_r[g]);
            end else begin
                m_ready <= 1'b1;
            end
        end

        always @(negedge clk) begin
            check($sformatf("lane%0d tx", g), 32'(tx_w[g]), 32'(m_act ? m_frame[m_pos] : 1'b1));
            check($sformatf("lane%0d busy", g), 32'(busy_w[g]), 32'(m_act));
            check($sformatf("lane%0d baud_en", g), 32'(baud_en_w[g]), 32'(m_act));
            check($sformatf("lane%0d tx_ready", g), 32'(ready_w[g]), 32'(m_ready));
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input int g, input logic [7:0] d, input bit hold);
        int n = 0;
        tx_data_r[g]  = d;
        tx_valid_r[g] = 1'b1;
        while (n < 5000) begin
            @(negedge clk);
            if (ready_w[g]) break;
            n++;
        end
        if (n >= 5000) begin
            errors++;
            $display("FAIL send lane%0d: no tx_ready within 5000 cycles", g);
        end
        @(posedge clk);
        #1;
        if (!hold) tx_valid_r[g] = 1'b0;
    endtask

    // Samples the line mid-bit until busy drops; returns at that negedge.
    task automatic rx_frame(input int g, output logic [15:0] bits, output int len, output int hi_run);
        int k = 0;
        bits   = '1;
        len    = 0;
        hi_run = 0;
        while (len < 5000) begin
            @(negedge clk);
            if (!busy_w[g]) break;
            if (len % period == period / 2 && k < 16) begin
                bits[k] = tx_w[g];
                k++;
            end
            hi_run = tx_w[g] ? hi_run + 1 : 0;
            len++;
        end
        if (len >= 5000) begin
            errors++;
            $display("FAIL rx lane%0d: frame did not end within 5000 cycles", g);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] b;
        int          len;
        int          hr;
        int          nb;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tx_valid_r[i] = 1'b0;
            tx_data_r[i]  = 8'h00;
        end
        repeat (3) @(posedge clk);
        #3;
        check("reset tx_ready", 32'(ready_w[0]), 32'd0);
        check("reset tx", 32'(tx_w[0]), 32'd1);
        rst = 1'b0;
        #1;
        check("release tx_ready before edge", 32'(ready_w[0]), 32'd0);
        idle(1);
        check("tx_ready after release", 32'(ready_w[0]), 32'd1);

        // 0x55 at 217 cycles per bit
        period = 217;
        send(0, 8'h55, 1'b0);
        rx_frame(0, b, len, hr);
        check("0x55 start+data", 32'(b[8:0]), 32'h0AA);
        check("0x55 stop", 32'(b[9+PB]), 32'd1);
        check("0x55 frame length", 32'(len), 32'((10 + PB) * 217));
        check("0x55 ready at end", 32'(ready_w[0]), 32'd1);

        period = 6;
`ifdef UART_TX_PARITY_EN
        idle(2);
        send(0, 8'h55, 1'b0);
        rx_frame(0, b, len, hr);
        check("parity 0x55", 32'(b[9]), 32'd0);
        check("parity 0x55 length", 32'(len), 32'd66);
        idle(1);
        send(0, 8'h07, 1'b0);
        rx_frame(0, b, len, hr);
        check("parity 0x07 data", 32'(b[8:1]), 32'h07);
        check("parity 0x07", 32'(b[9]), 32'd1);
        check("parity 0x07 length", 32'(len), 32'd66);
`endif

        // Back-to-back with tx_valid held high
        idle(2);
        send(0, 8'hA5, 1'b1);
        tx_data_r[0] = 8'h3C;
        rx_frame(0, b, len, hr);
        check("b2b first data", 32'(b[8:1]), 32'hA5);
        check("b2b gap baud_en low", 32'(baud_en_w[0]), 32'd0);
        idle(1);
        check("b2b second started", 32'(busy_w[0]), 32'd1);
        tx_valid_r[0] = 1'b0;
        rx_frame(0, b, len, hr);
        check("b2b second data", 32'(b[8:1]), 32'h3C);
        check("b2b second length", 32'(len), 32'((10 + PB) * 6));

        // Reset during data bit 3 of 0xFF
        idle(2);
        send(0, 8'hFF, 1'b0);
        repeat (4 * period + period / 2) @(posedge clk);
        #2;
        check("pre-reset baud_en", 32'(baud_en_w[0]), 32'd1);
        check("pre-reset busy", 32'(busy_w[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("async reset tx", 32'(tx_w[0]), 32'd1);
        check("async reset baud_en", 32'(baud_en_w[0]), 32'd0);
        check("async reset busy", 32'(busy_w[0]), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("mid-frame release tx_ready", 32'(ready_w[0]), 32'd0);
        idle(1);
        check("mid-frame ready after edge", 32'(ready_w[0]), 32'd1);
        check("abandoned frame idle", 32'(busy_w[0]), 32'd0);
        send(0, 8'h00, 1'b0);
        rx_frame(0, b, len, hr);
        check("after reset 0x00", 32'(b[8:0]), 32'h000);
        check("after reset length", 32'(len), 32'((10 + PB) * 6));

        // tx_data change and tx_valid pulse while busy
        idle(2);
        send(0, 8'h12, 1'b0);
        fork
            rx_frame(0, b, len, hr);
            begin
                repeat (3 * period) @(posedge clk);
                #1;
                tx_data_r[0] = 8'hEE;
                repeat (2 * period) @(posedge clk);
                #1;
                tx_valid_r[0] = 1'b1;
                @(posedge clk);
                #1;
                tx_valid_r[0] = 1'b0;
            end
        join
        check("latched 0x12", 32'(b[8:1]), 32'h12);
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_w[0]) nb++;
        end
        check("no second frame", 32'(nb), 32'd0);

        // Two stop bits, 0x00, 217 cycles per bit
        period = 217;
        idle(2);
        send(1, 8'h00, 1'b0);
        rx_frame(1, b, len, hr);
        check("2stop data", 32'(b[8:0]), 32'h000);
        check("2stop high run", 32'(hr), 32'd434);
        check("2stop ready", 32'(ready_w[1]), 32'd1);
        check("2stop length", 32'(len), 32'((11 + PB) * 217));

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning the number of payload bits per frame (legal values 5..8).
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning the number of stop bits per frame (legal values 1 or 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port tx_data, input, DATA_BITS bits: the payload, sampled on acceptance.
REQ-006 SHALL have port tx_valid, input, 1 bit: the upstream offers tx_data.
REQ-007 SHALL have port tx_ready, output, 1 bit: the framer can accept a byte this cycle.
REQ-008 SHALL have port baud_en, output, 1 bit: the enable to the baud pulse generator.
REQ-009 SHALL have port baud_pulse, input, 1 bit: a one-cycle bit-period tick from the baud pulse generator.
REQ-010 SHALL have port tx, output, 1 bit: the serial line, idle high.
REQ-011 SHALL have port busy, output, 1 bit: a frame is in progress.

Function
REQ-012 SHALL implement states IDLE, START, DATA, PARITY (only when UART_TX_PARITY_EN is defined) and STOP.
REQ-013 SHALL drive tx_ready high only in IDLE.
REQ-014 SHALL accept a byte when tx_valid && tx_ready, latch tx_data into a shift register, and enter START on the next edge.
REQ-015 SHALL drive tx from a register: 0 in START, shift-register LSB in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-016 SHALL make tx go low on the first clock edge after acceptance, giving 1-cycle latency from acceptance to the start-bit edge.
REQ-017 SHALL assert baud_en, registered, in every state except IDLE, and deassert it for at least one cycle between frames so the generator restarts its phase.
REQ-018 SHALL advance state only on cycles where baud_pulse=1; it SHALL ignore baud_pulse in IDLE.
REQ-019 SHALL transition START->DATA on baud_pulse.
REQ-020 SHALL, in DATA, shift right on each baud_pulse and count with a bit counter of width clog2(DATA_BITS); after the DATA_BITS-th pulse it SHALL go to PARITY, or to STOP when parity is not compiled in.
REQ-021 SHALL hold STOP for STOP_BITS baud_pulses, then go to IDLE, where tx_ready is high on the following cycle.
REQ-022 SHALL drive busy = (state != IDLE), registered.
REQ-023 SHALL ignore tx_valid while busy, and SHALL NOT alter the latched data when tx_data changes mid-frame.
REQ-024 SHALL finish the frame normally if baud_pulse coincides with the final stop-bit cycle and tx_valid is high in the same cycle; the new byte is accepted only once the framer is back in IDLE.
REQ-025 SHALL produce a frame length of exactly 1+DATA_BITS+P+STOP_BITS baud periods, where P is 1 with parity and 0 without.

Reset
REQ-026 SHALL, while rst=1 (immediately, without waiting for clk), force state=IDLE, tx=1, baud_en=0, busy=0, tx_ready=0, and clear the shift register and counters to 0.
REQ-027 SHALL drive tx_ready=1 on the first clock edge after rst deasserts.
REQ-028 SHALL, on reset mid-frame, abandon the frame: tx returns high at once and no partial frame resumes.

Configuration
REQ-029 SHALL, when macro UART_TX_PARITY_EN is defined, insert a PARITY state after DATA that transmits even parity, i.e. the XOR of the DATA_BITS payload bits.
REQ-030 SHALL, when UART_TX_PARITY_EN is undefined, contain no PARITY state or parity logic, and DATA SHALL proceed directly to STOP.

Verification
REQ-031 SHALL cover this case: paired with the baud pulse generator at 25 MHz and 115200 baud (217-cycle bit period), send 0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 217+/-1 cycles, total 2170 cycles.
REQ-032 SHALL cover this case: with UART_TX_PARITY_EN defined, send 0x55 then 0x07 -> parity bit 0 for 0x55 and 1 for 0x07, frame length 11 bit periods.
REQ-033 SHALL cover this case: hold tx_valid=1 continuously for bytes 0xA5 then 0x3C -> two complete frames, second start bit begins within 3 cycles of the first stop bit ending, and baud_en low for at least 1 cycle between them.
REQ-034 SHALL cover this case: assert rst during DATA bit 3 of 0xFF -> tx=1 and baud_en=0 immediately, tx_ready=1 one edge after release, and the next byte 0x00 is sent cleanly.
REQ-035 SHALL cover this case: change tx_data from 0x12 to 0xEE mid-frame and pulse tx_valid while busy -> the frame carries 0x12, and no second frame starts until re-accepted in IDLE.
REQ-036 SHALL cover this case: STOP_BITS=2 with 0x00 -> tx high for 434 cycles after the last data bit before tx_ready rises.
